// File: rtl/rv_fifo.sv
// rv_fifo: ready/valid FIFO with circular storage, synchronous flush and optional fall-through.
// Ports: clk/rst (sync, active-high), flush clears all entries; in_valid/in_ready/in_data producer side;
// out_valid/out_ready/out_data consumer side; count/full/empty occupancy status.
// Define RV_FIFO_BYPASS_EN to let a beat arriving at an empty FIFO pass straight to the output.
module rv_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rv_fifo: DEPTH must be a power of two and at least 2");
    end
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          byp, wr_en, rd_en;
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty    = wr_q == rd_q;
    assign count    = wr_q - rd_q;
    assign in_ready = !full && !flush;
`ifdef RV_FIFO_BYPASS_EN
    assign byp = empty && in_valid && !flush;
`else
    assign byp = 1'b0;
`endif
    assign out_valid = (!empty || byp) && !flush;
    assign out_data  = byp ? in_data : mem_q[rd_q[AW-1:0]];
    // A bypassed beat that is consumed immediately never touches storage.
    assign wr_en = in_valid && in_ready && !(byp && out_ready) && !rst;
    assign rd_en = out_valid && out_ready && !empty;
    always_comb begin
        wr_d = (rst || flush) ? '0 : wr_q + {{AW{1'b0}}, wr_en};
        rd_d = (rst || flush) ? '0 : rd_q + {{AW{1'b0}}, rd_en};
    end
    always_ff @(posedge clk) begin
        wr_q <= wr_d;
        rd_q <= rd_d;
        if (wr_en) mem_q[wr_q[AW-1:0]] <= in_data;
    end
endmodule

// File: doc/rv_fifo.md
RV_FIFO -- requirements
Module: rv_fifo

Interface
REQ-001 SHALL have parameter DW, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; power of two and at least 2, otherwise elaboration fails.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all entries (pipeline kill).
REQ-006 SHALL have port in_valid, input, 1, producer has data.
REQ-007 SHALL have port in_ready, output, 1, FIFO accepts data.
REQ-008 SHALL have port in_data, input, DW, producer payload.
REQ-009 SHALL have port out_valid, output, 1, FIFO presents data.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts data.
REQ-011 SHALL have port out_data, output, DW, head payload.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, occupied entries, 0..DEPTH.
REQ-013 SHALL have ports full and empty, output, 1 each, count==DEPTH and count==0.

Function
REQ-014 SHALL store entries in a circular array; write and read pointers are $clog2(DEPTH)+1 bits, with the MSB as wrap bit.
REQ-015 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready; storage only changes on push and pop.
REQ-016 SHALL drive in_ready = !full && !flush; in_ready SHALL NOT depend on out_ready.
REQ-017 SHALL drive out_valid = !empty && !flush in the base build, and out_data = entry at the read pointer.
REQ-018 On push, SHALL write in_data at the write pointer and increment the pointer modulo 2*DEPTH.
REQ-019 On pop, SHALL increment the read pointer modulo 2*DEPTH.
REQ-020 On simultaneous push and pop, SHALL perform both; count is unchanged.
REQ-021 SHALL derive full as pointer low bits equal and wrap bits differing; empty as pointers fully equal; count = wr_ptr - rd_ptr.
REQ-022 SHALL give one-cycle latency in the base build: data pushed in cycle N is first visible on out_data in cycle N+1.
REQ-023 SHALL keep out_valid asserted and out_data stable while out_valid && !out_ready, until pop or flush.
REQ-024 On flush, SHALL zero both pointers at the next edge, discard all entries, and perform no push or pop in that cycle; flush has priority over push and pop.
REQ-025 When full, SHALL NOT push even if a pop occurs in the same cycle (in_ready is already 0).

Reset
REQ-026 rst SHALL zero both pointers, giving count=0, empty=1, full=0, out_valid=0, in_ready=1 in the cycle after reset.
REQ-027 rst SHALL take priority over flush, push and pop; storage contents are not reset.
REQ-028 Assertion of rst mid-stream SHALL discard all entries, identical to a flush.

Configuration
REQ-029 Macro RV_FIFO_BYPASS_EN SHALL enable fall-through: when empty && in_valid && !flush, out_valid=1 and out_data=in_data combinationally.
REQ-030 With RV_FIFO_BYPASS_EN, if out_ready is also 1 in that cycle, the beat SHALL pass with zero latency, with no write and count staying 0; if out_ready is 0, the beat SHALL be written normally.
REQ-031 Without RV_FIFO_BYPASS_EN, SHALL behave per REQ-017/REQ-022 with no in-to-out combinational path.

Verification
REQ-032 Reset then idle -> count=0, empty=1, in_ready=1, out_valid=0.
REQ-033 DEPTH=4, out_ready=0, push 0xA1,0xA2,0xA3,0xA4, then attempt 0xA5 -> full=1, in_ready=0, count=4; then out_ready=1 -> pops A1..A4 in order and 0xA5 is never stored.
REQ-034 Streaming with in_valid=1, out_ready=1 for 10 cycles, data 0..9 -> all 10 pops in order; base build: count steady at 1, out_data lags in_data by 1 cycle; bypass build: count=0, out_data==in_data each cycle.
REQ-035 count=3 with push and pop asserted together on the same cycle -> count stays 3; head advances one entry; pushed value lands at the tail.
REQ-036 count=2, flush=1 for one cycle alongside in_valid=1 -> next cycle count=0, out_valid=0, and the flush-cycle data is not stored.
REQ-037 Push more than 2*DEPTH beats, interleaving random out_ready -> output sequence equals input sequence across pointer wrap, and full/empty agree with a reference count.
